// File: rtl/hazard_stall_unit_if.sv
// Pipeline hazard control bundle: ID/EXE observations in, stall/bubble/flush controls out.
interface hazard_stall_unit_if #(
   parameter int CNT_WIDTH = 32
);
   logic [4:0]           addr1;
   logic [4:0]           addr2;
   logic                 id_uses_rs1;
   logic                 id_uses_rs2;
   logic [6:0]           id_opcode;
   logic [4:0]           exe_addr;
   logic                 exe_mem_read;
   logic                 exe_div;
   logic                 branch_taken;
   logic                 pc_stall;
   logic                 if_id_stall;
   logic                 id_exe_stall;
   logic                 id_exe_bubble;
   logic                 exe_mem_bubble;
   logic                 if_id_flush;
   logic                 div_busy;
   logic [CNT_WIDTH-1:0] stall_count;

   modport master (
      output addr1, addr2, id_uses_rs1, id_uses_rs2, id_opcode,
             exe_addr, exe_mem_read, exe_div, branch_taken,
      input  pc_stall, if_id_stall, id_exe_stall, id_exe_bubble,
             exe_mem_bubble, if_id_flush, div_busy, stall_count
   );

   modport slave (
      input  addr1, addr2, id_uses_rs1, id_uses_rs2, id_opcode,
             exe_addr, exe_mem_read, exe_div, branch_taken,
      output pc_stall, if_id_stall, id_exe_stall, id_exe_bubble,
             exe_mem_bubble, if_id_flush, div_busy, stall_count
   );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the hazards operand forwarding cannot resolve:
// load-use, multi-cycle divide occupancy and taken-branch redirects.
module hazard_stall_unit #(
   parameter int DIV_LATENCY = 32,
   parameter int CNT_WIDTH   = 32
) (
   input logic                clk,
   input logic                reset,
   hazard_stall_unit_if.slave bus
);
   localparam int DW = $clog2(DIV_LATENCY);
   localparam logic [6:0]           STORE_OPCODE = 7'b0100011;
   localparam logic [DW-1:0]        DIV_LOAD     = DW'(DIV_LATENCY - 2);
   localparam logic [DW-1:0]        DIV_ONE      = DW'(1'b1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1'b1);

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      DIV_WAIT = 1'b1
   } state_t;

   state_t               state_r;
   logic [DW-1:0]        div_cnt_r;
   logic                 div_busy_r;
   logic [CNT_WIDTH-1:0] stall_count_r;

   logic lu_s;
   logic pc_stall_s;
   logic if_id_stall_s;
   logic id_exe_stall_s;
   logic id_exe_bubble_s;
   logic exe_mem_bubble_s;
   logic if_id_flush_s;

   // Store data is forwarded at MEM, so a store's rs2 alone never needs a load-use bubble.
   function automatic logic detect_load_use(
      input logic       mem_read,
      input logic [4:0] dst,
      input logic [4:0] rs1,
      input logic [4:0] rs2,
      input logic       uses_rs1,
      input logic       uses_rs2,
      input logic [6:0] opcode
   );
      logic rs1_hit;
      logic rs2_hit;
      rs1_hit = uses_rs1 && (rs1 == dst);
      rs2_hit = uses_rs2 && (rs2 == dst) && (opcode != STORE_OPCODE);
      return mem_read && (dst != 5'd0) && (rs1_hit || rs2_hit);
   endfunction

   assign lu_s = detect_load_use(bus.exe_mem_read, bus.exe_addr, bus.addr1, bus.addr2,
                                 bus.id_uses_rs1, bus.id_uses_rs2, bus.id_opcode);

   // Pipeline control decode: divide wait dominates, then branch, divide start, load-use.
   always_comb begin
      pc_stall_s       = 1'b0;
      if_id_stall_s    = 1'b0;
      id_exe_stall_s   = 1'b0;
      id_exe_bubble_s  = 1'b0;
      exe_mem_bubble_s = 1'b0;
      if_id_flush_s    = 1'b0;
      case (state_r)
         DIV_WAIT: begin
            pc_stall_s       = 1'b1;
            if_id_stall_s    = 1'b1;
            id_exe_stall_s   = 1'b1;
            exe_mem_bubble_s = 1'b1;
         end
         RUN: begin
            if (bus.branch_taken) begin
               if_id_flush_s   = 1'b1;
               id_exe_bubble_s = 1'b1;
            end else if (bus.exe_div) begin
               pc_stall_s       = 1'b1;
               if_id_stall_s    = 1'b1;
               id_exe_stall_s   = 1'b1;
               exe_mem_bubble_s = 1'b1;
            end else if (lu_s) begin
               pc_stall_s      = 1'b1;
               if_id_stall_s   = 1'b1;
               id_exe_bubble_s = 1'b1;
            end else begin
               pc_stall_s = 1'b0;
            end
         end
         default: begin
            pc_stall_s = 1'b0;
         end
      endcase
   end

   // Divide occupancy FSM and stall-cycle performance counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= RUN;
         div_cnt_r     <= '0;
         div_busy_r    <= 1'b0;
         stall_count_r <= '0;
      end else begin
         if (pc_stall_s) begin
            stall_count_r <= stall_count_r + CNT_ONE;
         end else begin
            stall_count_r <= stall_count_r;
         end
         case (state_r)
            RUN: begin
               if (!bus.branch_taken && bus.exe_div) begin
                  state_r    <= DIV_WAIT;
                  div_cnt_r  <= DIV_LOAD;
                  div_busy_r <= 1'b1;
               end else begin
                  state_r    <= RUN;
                  div_busy_r <= 1'b0;
               end
            end
            DIV_WAIT: begin
               // Last wait cycle: the result enters EXE/MEM on the following cycle.
               if (div_cnt_r == '0) begin
                  state_r    <= RUN;
                  div_busy_r <= 1'b0;
               end else begin
                  div_cnt_r  <= div_cnt_r - DIV_ONE;
                  div_busy_r <= 1'b1;
               end
            end
            default: begin
               state_r    <= RUN;
               div_cnt_r  <= '0;
               div_busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pc_stall       = pc_stall_s;
   assign bus.if_id_stall    = if_id_stall_s;
   assign bus.id_exe_stall   = id_exe_stall_s;
   assign bus.id_exe_bubble  = id_exe_bubble_s;
   assign bus.exe_mem_bubble = exe_mem_bubble_s;
   assign bus.if_id_flush    = if_id_flush_s;
   assign bus.div_busy       = div_busy_r;
   assign bus.stall_count    = stall_count_r;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios plus randomized
// traffic against a cycle-level occupancy model.
module tb_hazard_stall_unit;
   localparam int DIV_LATENCY = 4;
   localparam int CNT_WIDTH   = 8;
   localparam logic [6:0] STORE_OP = 7'b0100011;
   localparam logic [6:0] R_TYPE   = 7'b0110011;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   fails = 0;

   // Model: cycles of divide occupancy still owed, and the stall count.
   int   m_div_left = 0;
   int   m_count = 0;
   bit   m_valid = 1'b0;
   logic [6:0] exp_v;
   logic [6:0] obs_v;
   logic [CNT_WIDTH-1:0] exp_cnt;

   hazard_stall_unit_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

   hazard_stall_unit #(.DIV_LATENCY(DIV_LATENCY), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // {pc_stall, if_id_stall, id_exe_stall, id_exe_bubble, exe_mem_bubble, if_id_flush, div_busy}
   assign obs_v = {bus.pc_stall, bus.if_id_stall, bus.id_exe_stall, bus.id_exe_bubble,
                   bus.exe_mem_bubble, bus.if_id_flush, bus.div_busy};

   task automatic model_eval();
      logic lu;
      lu = bus.exe_mem_read && (bus.exe_addr != 5'd0) &&
           ((bus.id_uses_rs1 && bus.addr1 == bus.exe_addr) ||
            (bus.id_uses_rs2 && bus.addr2 == bus.exe_addr && bus.id_opcode != STORE_OP));
      if (m_div_left > 0)         exp_v = 7'b1110101;
      else if (bus.branch_taken)  exp_v = 7'b0001010;
      else if (bus.exe_div)       exp_v = 7'b1110100;
      else if (lu)                exp_v = 7'b1101000;
      else                        exp_v = 7'b0000000;
      exp_cnt = m_count[CNT_WIDTH-1:0];
   endtask

   task automatic model_advance();
      if (reset) begin
         m_div_left = 0;
         m_count    = 0;
      end else begin
         if (exp_v[6]) m_count = (m_count + 1) % (1 << CNT_WIDTH);
         if (m_div_left > 0) m_div_left--;
         else if (!bus.branch_taken && bus.exe_div) m_div_left = DIV_LATENCY - 1;
      end
   endtask

   // Drive one cycle of inputs after the falling edge and compute expected outputs.
   task automatic tick(input logic rs, input logic mr, input logic [4:0] ea,
                       input logic [4:0] a1, input logic [4:0] a2, input logic u1,
                       input logic u2, input logic [6:0] op, input logic dv, input logic br);
      @(negedge clk);
      if (m_valid) model_advance();
      reset            = rs;
      bus.exe_mem_read = mr;
      bus.exe_addr     = ea;
      bus.addr1        = a1;
      bus.addr2        = a2;
      bus.id_uses_rs1  = u1;
      bus.id_uses_rs2  = u2;
      bus.id_opcode    = op;
      bus.exe_div      = dv;
      bus.branch_taken = br;
      #1;
      model_eval();
      m_valid = 1'b1;
   endtask

   task automatic idle(input logic rs);
      tick(rs, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, R_TYPE, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      idle(1'b1);
      idle(1'b1);
      idle(1'b0);
      checks++;
      if (obs_v !== 7'b0000000) begin
         fails++; $display("FAIL reset_outputs: got %b expected %b", obs_v, 7'b0000000);
      end
      checks++;
      if (bus.stall_count !== 8'd0) begin
         fails++; $display("FAIL reset_count: got %0d expected 0", bus.stall_count);
      end
   endtask

   task automatic test_load_use();
      tick(1'b0, 1'b1, 5'd1, 5'd2, 5'd1, 1'b1, 1'b1, R_TYPE, 1'b0, 1'b0);
      checks++;
      if (obs_v !== 7'b1101000 || obs_v !== exp_v) begin
         fails++; $display("FAIL load_use: got %b expected %b", obs_v, 7'b1101000);
      end
      idle(1'b0);
      checks++;
      if (obs_v !== 7'b0000000 || bus.stall_count !== 8'd1) begin
         fails++; $display("FAIL load_use_after: got %b cnt %0d expected 0000000 cnt 1", obs_v, bus.stall_count);
      end
   endtask

   task automatic test_store();
      tick(1'b0, 1'b1, 5'd1, 5'd3, 5'd1, 1'b1, 1'b1, STORE_OP, 1'b0, 1'b0);
      checks++;
      if (obs_v !== 7'b0000000 || obs_v !== exp_v) begin
         fails++; $display("FAIL store_rs2_only: got %b expected %b", obs_v, 7'b0000000);
      end
      tick(1'b0, 1'b1, 5'd1, 5'd1, 5'd1, 1'b1, 1'b1, STORE_OP, 1'b0, 1'b0);
      checks++;
      if (obs_v !== 7'b1101000 || obs_v !== exp_v) begin
         fails++; $display("FAIL store_rs1_hit: got %b expected %b", obs_v, 7'b1101000);
      end
   endtask

   task automatic test_x0();
      tick(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, R_TYPE, 1'b0, 1'b0);
      checks++;
      if (obs_v !== 7'b0000000 || obs_v !== exp_v) begin
         fails++; $display("FAIL x0_no_hazard: got %b expected %b", obs_v, 7'b0000000);
      end
      tick(1'b0, 1'b1, 5'd5, 5'd6, 5'd4, 1'b1, 1'b1, R_TYPE, 1'b0, 1'b0);
      checks++;
      if (obs_v !== 7'b0000000 || obs_v !== exp_v) begin
         fails++; $display("FAIL no_dependency: got %b expected %b", obs_v, 7'b0000000);
      end
   endtask

   task automatic test_divide();
      int base;
      idle(1'b0);
      base = m_count;
      tick(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, R_TYPE, 1'b1, 1'b0);
      checks++;
      if (obs_v !== 7'b1110100 || obs_v !== exp_v) begin
         fails++; $display("FAIL div_start: got %b expected %b", obs_v, 7'b1110100);
      end
      for (int i = 0; i < DIV_LATENCY - 1; i++) begin
         // Branch and load-use inputs mid-wait must be ignored.
         if (i == 1) tick(1'b0, 1'b1, 5'd1, 5'd1, 5'd1, 1'b1, 1'b1, R_TYPE, 1'b0, 1'b1);
         else        idle(1'b0);
         checks++;
         if (obs_v !== 7'b1110101 || obs_v !== exp_v) begin
            fails++; $display("FAIL div_wait_%0d: got %b expected %b", i, obs_v, 7'b1110101);
         end
      end
      idle(1'b0);
      checks++;
      if (obs_v !== 7'b0000000 || bus.stall_count !== 8'((base + 4) % 256)) begin
         fails++; $display("FAIL div_done: got %b cnt %0d expected 0000000 cnt %0d", obs_v, bus.stall_count, (base + 4) % 256);
      end
   endtask

   task automatic test_branch();
      int base;
      base = m_count;
      tick(1'b0, 1'b1, 5'd1, 5'd1, 5'd1, 1'b1, 1'b1, R_TYPE, 1'b0, 1'b1);
      checks++;
      if (obs_v !== 7'b0001010 || obs_v !== exp_v) begin
         fails++; $display("FAIL branch_over_lu: got %b expected %b", obs_v, 7'b0001010);
      end
      tick(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, R_TYPE, 1'b1, 1'b1);
      checks++;
      if (obs_v !== 7'b0001010 || obs_v !== exp_v) begin
         fails++; $display("FAIL branch_over_div: got %b expected %b", obs_v, 7'b0001010);
      end
      idle(1'b0);
      checks++;
      if (obs_v !== 7'b0000000 || bus.stall_count !== 8'(base)) begin
         fails++; $display("FAIL branch_after: got %b cnt %0d expected 0000000 cnt %0d", obs_v, bus.stall_count, base);
      end
   endtask

   task automatic test_reset_mid_div();
      tick(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, R_TYPE, 1'b1, 1'b0);
      idle(1'b0);
      idle(1'b1);
      checks++;
      if (obs_v !== exp_v) begin
         fails++; $display("FAIL reset_mid_div_wait: got %b expected %b", obs_v, exp_v);
      end
      idle(1'b0);
      checks++;
      if (obs_v !== 7'b0000000 || bus.stall_count !== 8'd0) begin
         fails++; $display("FAIL reset_mid_div_after: got %b cnt %0d expected 0000000 cnt 0", obs_v, bus.stall_count);
      end
   endtask

   task automatic test_wrap();
      idle(1'b1);
      for (int i = 0; i < 256; i++) begin
         tick(1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, R_TYPE, 1'b0, 1'b0);
      end
      checks++;
      if (bus.stall_count !== 8'd255 || obs_v !== 7'b1101000) begin
         fails++; $display("FAIL wrap_before: got cnt %0d out %b expected cnt 255 out 1101000", bus.stall_count, obs_v);
      end
      idle(1'b0);
      checks++;
      if (bus.stall_count !== 8'd0) begin
         fails++; $display("FAIL wrap_after: got %0d expected 0", bus.stall_count);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         tick(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
              1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 2) == 0) ? STORE_OP : R_TYPE,
              ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
         checks++;
         if (obs_v !== exp_v) begin
            fails++; $display("FAIL random_out_%0d: got %b expected %b", i, obs_v, exp_v);
         end
         checks++;
         if (bus.stall_count !== exp_cnt) begin
            fails++; $display("FAIL random_cnt_%0d: got %0d expected %0d", i, bus.stall_count, exp_cnt);
         end
      end
   endtask

   initial begin
      reset            = 1'b1;
      bus.exe_mem_read = 1'b0;
      bus.exe_addr     = 5'd0;
      bus.addr1        = 5'd0;
      bus.addr2        = 5'd0;
      bus.id_uses_rs1  = 1'b0;
      bus.id_uses_rs2  = 1'b0;
      bus.id_opcode    = R_TYPE;
      bus.exe_div      = 1'b0;
      bus.branch_taken = 1'b0;
      test_reset();
      test_load_use();
      test_store();
      test_x0();
      test_divide();
      test_branch();
      test_reset_mid_div();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall/flush controller; the complement of the forwarding unit. It handles every dependency that operand forwarding cannot resolve.
- Sits beside the forwarding unit.
- Observes ID and EXE stages and drives the pipeline-register enables and bubbles.
- Covers three cases: load-use hazards (one bubble), multi-cycle RV32M divide/remainder occupancy (counted stall), and taken branch/jump redirects (flush).

Parameters:
- DIV_LATENCY, 32, total EXE cycles occupied by a DIV/DIVU/REM/REMU op (≥2).
- CNT_WIDTH, 32, width of the stall-cycle performance counter.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- ADDR1  in  5  ID-stage rs1 address.
- ADDR2  in  5  ID-stage rs2 address.
- ID_USES_RS1  in  1  ID instruction reads rs1.
- ID_USES_RS2  in  1  ID instruction reads rs2.
- ID_OPCODE  in  7  ID-stage opcode (encodings header values).
- EXE_ADDR  in  5  EXE-stage destination register.
- EXE_MEM_READ  in  1  EXE instruction is a load.
- EXE_DIV  in  1  EXE instruction is a divide/remainder op.
- BRANCH_TAKEN  in  1  EXE resolved a taken branch/JAL/JALR.
- PC_STALL  out  1  hold PC.
- IF_ID_STALL  out  1  hold IF/ID register.
- ID_EXE_STALL  out  1  hold ID/EXE register.
- ID_EXE_BUBBLE  out  1  load NOP into ID/EXE.
- EXE_MEM_BUBBLE  out  1  load NOP into EXE/MEM.
- IF_ID_FLUSH  out  1  load NOP into IF/ID.
- DIV_BUSY  out  1  divide in progress (state DIV_WAIT).
- STALL_COUNT  out  CNT_WIDTH  stall cycles since reset.

Behaviour:
- States: RUN, DIV_WAIT. Internal down-counter DIV_CNT, width clog2(DIV_LATENCY).
- Reset (synchronous, RESET=1 at posedge):
  - state=RUN, DIV_CNT=0, STALL_COUNT=0.
  - All combinational outputs are 0 while in RUN with idle inputs.
  - Reset mid-DIV_WAIT aborts the divide immediately: next cycle is RUN.
- Load-use detect, combinational (LU):
  - LU = EXE_MEM_READ & EXE_ADDR!=0 & ((ID_USES_RS1 & ADDR1==EXE_ADDR) | (ID_USES_RS2 & ADDR2==EXE_ADDR)).
  - Exception: ID_OPCODE==STORE_OPCODE with only the rs2 match does not raise LU, because store data is forwarded at MEM.
- RUN outputs:
  - BRANCH_TAKEN=1: IF_ID_FLUSH=1, ID_EXE_BUBBLE=1, all stalls 0. Branch overrides LU.
  - Else EXE_DIV=1: PC_STALL=IF_ID_STALL=ID_EXE_STALL=1, EXE_MEM_BUBBLE=1. Next state DIV_WAIT, DIV_CNT=DIV_LATENCY-2.
  - Else LU=1: PC_STALL=IF_ID_STALL=1, ID_EXE_BUBBLE=1. Exactly one bubble, no state change; the next cycle is resolved by the forwarding unit.
  - Else all outputs 0.
- DIV_WAIT outputs:
  - PC_STALL=IF_ID_STALL=ID_EXE_STALL=1, EXE_MEM_BUBBLE=1, DIV_BUSY=1.
  - BRANCH_TAKEN and LU are ignored (EXE holds the divide).
  - DIV_CNT decrements each cycle. When DIV_CNT==0, next state is RUN and all stalls drop the following cycle, so the divide result enters EXE/MEM then.
- Total EXE occupancy of a divide is exactly DIV_LATENCY cycles: 1 cycle in RUN plus DIV_LATENCY-1 cycles in DIV_WAIT.
- STALL_COUNT:
  - Increments by 1 on each posedge where PC_STALL=1 and RESET=0.
  - Wraps modulo 2^CNT_WIDTH.
  - Flush-only cycles are not counted.
- Output priority in RUN, high to low: BRANCH_TAKEN, EXE_DIV, LU.
- EXE_DIV and BRANCH_TAKEN never both assert; if they do, the branch wins and no divide wait is started.
- Register x0 never causes a hazard.

Test Plan:
1. Load-use:
   - Stimulus: EXE_MEM_READ=1, EXE_ADDR=1, ADDR1=2, ADDR2=1, ID_USES_RS2=1, ID_OPCODE=R_TYPE.
   - Response: PC_STALL=IF_ID_STALL=ID_EXE_BUBBLE=1 for one cycle; STALL_COUNT=1.
2. Store exception:
   - Stimulus: same as 1, but ID_OPCODE=STORE_OPCODE, ADDR1=3.
   - Response: all outputs 0. With ADDR1=1 instead, LU stalls for one cycle.
3. x0 / no dependency:
   - Stimulus: EXE_MEM_READ=1, EXE_ADDR=0, ADDR1=0, ID_USES_RS1=1.
   - Response: no stall. EXE_ADDR=5, ADDR1=6, ADDR2=4 also gives no stall.
4. Divide, DIV_LATENCY=4:
   - Stimulus: EXE_DIV=1 for 1 cycle.
   - Response: PC_STALL high for exactly 4 consecutive cycles; DIV_BUSY high for cycles 2–4; EXE_MEM_BUBBLE high for all 4; STALL_COUNT=4 afterwards.
5. Branch priority:
   - Stimulus: BRANCH_TAKEN=1 together with LU conditions.
   - Response: IF_ID_FLUSH=ID_EXE_BUBBLE=1, PC_STALL=0, STALL_COUNT unchanged.
6. Reset mid-divide:
   - Stimulus: RESET=1 in cycle 2 of DIV_WAIT.
   - Response: next cycle state RUN, DIV_BUSY=0, all stalls 0, STALL_COUNT=0.
